debounce_trigger: RTL and testbench
===================================

DEBOUNCE_TRIGGER -- requirements
Module: debounce_trigger

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flip-flops on in_btn, legal range 2..4.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 5: number of confirming cycles before a level change is accepted, legal range 1..1023.
REQ-003 The block SHALL have port in_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port in_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_btn, input, 1 bit: raw, asynchronous, bouncing input.
REQ-006 The block SHALL have port out_level, output, 1 bit: debounced level.
REQ-007 The block SHALL have port out_rise, output, 1 bit: one-cycle pulse on an accepted 0->1 change; this is the start trigger for the downstream sequencer.
REQ-008 The block SHALL have port out_fall, output, 1 bit: one-cycle pulse on an accepted 1->0 change.
REQ-009 The block SHALL have port out_toggle, output, 1 bit: inverts on every accepted 0->1 change.
REQ-010 The block SHALL have port out_busy, output, 1 bit: high while in state RiseWait or FallWait.

Function
REQ-011 in_btn SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage is the synchronized input s, and no other logic SHALL read in_btn.
REQ-012 The FSM SHALL have exactly four states: Low, RiseWait, High, FallWait.
REQ-013 The wait counter SHALL be $clog2(STABLE_CYCLES+1) bits wide and SHALL never exceed STABLE_CYCLES-1.
REQ-014 Low: if s=1, the FSM SHALL go to RiseWait and set ctr=0; otherwise it SHALL stay in Low.
REQ-015 RiseWait, s=0: the FSM SHALL return to Low, set ctr=0, and produce no pulse.
REQ-016 RiseWait, s=1 and ctr=STABLE_CYCLES-1: the FSM SHALL go to High, set out_level=1, pulse out_rise, invert out_toggle, and set ctr=0.
REQ-017 RiseWait, s=1, any other ctr value: the FSM SHALL increment ctr.
REQ-018 High and FallWait SHALL mirror Low and RiseWait with s inverted, setting out_level=0 and pulsing out_fall on acceptance.
REQ-019 All outputs SHALL be registered; out_rise and out_fall SHALL be high for exactly one cycle and SHALL never be high simultaneously.
REQ-020 Acceptance latency: let edge k be the first edge that samples the new in_btn value; the wait state SHALL be entered at edge k+SYNC_STAGES, and out_level and the pulse SHALL update at edge k+SYNC_STAGES+STABLE_CYCLES (defaults: k+7).
REQ-021 An in_btn change SHALL be accepted only if the value is held for at least STABLE_CYCLES+1 consecutive clock samples; any opposite sample inside the window SHALL restart detection from the idle state.
REQ-022 A bounce back to the original level during a wait SHALL leave out_level, out_toggle and all pulses unchanged.
REQ-023 With STABLE_CYCLES=1, a change SHALL be accepted on the edge after wait-state entry.

Reset
REQ-024 When in_rst=0, the block SHALL immediately, without waiting for a clock edge, clear the synchronizer to 0, set the state to Low and ctr=0, and drive out_level, out_rise, out_fall, out_toggle and out_busy to 0.
REQ-025 Reset asserted during RiseWait or FallWait SHALL abort the wait with no pulse at any time, including after reset release.
REQ-026 After reset release, the block SHALL resume normal operation on the first rising edge; if in_btn is held high through reset, one accepted rise SHALL follow after REQ-020 latency.

Verification
REQ-027 Clean press, defaults: in_btn 0->1 before edge k and held -> out_busy high from k+2; out_level=1, out_rise pulse and out_toggle=1 at edge k+7; no further pulses.
REQ-028 Glitch rejection: in_btn high for 5 cycles, then low -> out_level stays 0, no out_rise, out_busy falls back to 0; the same stimulus held for 6 cycles -> accepted.
REQ-029 Bouncy press: in_btn pattern 1,0,1,1,0 then 1 held -> exactly one out_rise, occurring 7 edges after the final 0->1 sample.
REQ-030 Release after press: in_btn 1->0 held -> one out_fall pulse 7 edges later; out_toggle stays 1; a second press/release cycle returns out_toggle to 0.
REQ-031 Reset during RiseWait at ctr=3, with in_btn held high -> all outputs 0 at once; after release, out_rise occurs exactly once, 7 edges after the first sample.
REQ-032 STABLE_CYCLES=1, SYNC_STAGES=3 -> accepted change at edge k+4; a 1-cycle glitch is rejected and a 2-cycle pulse is accepted.

Source files
------------

// File: rtl/debounce_trigger.sv
// Debounces a raw push-button input: synchronizer chain, four-state accept FSM,
// and registered level / rise / fall / toggle / busy outputs.
module debounce_trigger #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 5
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_btn,
  output logic out_level,
  output logic out_rise,
  output logic out_fall,
  output logic out_toggle,
  output logic out_busy
);

  localparam int unsigned CTR_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   toggle_q, toggle_d;
  logic                   busy_q, busy_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_btn};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      sync_q   <= '0;
      state_q  <= LOW;
      ctr_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = '0;
    case (state_q)
      LOW: begin
        if (s) state_d = RISE_WAIT;
      end
      RISE_WAIT: begin
        if (!s) state_d = LOW;
        else if (ctr_q == CTR_MAX) state_d = HIGH;
        else ctr_d = ctr_q + 1'b1;
      end
      HIGH: begin
        if (!s) state_d = FALL_WAIT;
      end
      FALL_WAIT: begin
        if (s) state_d = HIGH;
        else if (ctr_q == CTR_MAX) state_d = LOW;
        else ctr_d = ctr_q + 1'b1;
      end
      default: state_d = LOW;
    endcase
  end

  // Outputs are registered, so they are computed from the next state to line up
  // with the state transition edge.
  always_comb begin
    rise_d   = (state_q == RISE_WAIT) && s && (ctr_q == CTR_MAX);
    fall_d   = (state_q == FALL_WAIT) && !s && (ctr_q == CTR_MAX);
    level_d  = (state_d == HIGH) || (state_d == FALL_WAIT);
    toggle_d = toggle_q ^ rise_d;
    busy_d   = (state_d == RISE_WAIT) || (state_d == FALL_WAIT);
  end

  assign out_level  = level_q;
  assign out_rise   = rise_q;
  assign out_fall   = fall_q;
  assign out_toggle = toggle_q;
  assign out_busy   = busy_q;

endmodule

// File: tb/tb_debounce_trigger.sv
// Bench for debounce_trigger: two configurations (2/5 and 3/1) share one stimulus
// stream and are compared every cycle against a run-length model of acceptance.
module tb_debounce_trigger;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic in_btn = 1'b0;

  logic lvl0, rise0, fall0, tog0, busy0;
  logic lvl1, rise1, fall1, tog1, busy1;
  logic [4:0] d0, d1;

  assign d0 = {lvl0, rise0, fall0, tog0, busy0};
  assign d1 = {lvl1, rise1, fall1, tog1, busy1};

  debounce_trigger #(.SYNC_STAGES(2), .STABLE_CYCLES(5)) dut0 (
    .in_clk(in_clk), .in_rst(in_rst), .in_btn(in_btn),
    .out_level(lvl0), .out_rise(rise0), .out_fall(fall0),
    .out_toggle(tog0), .out_busy(busy0)
  );

  debounce_trigger #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut1 (
    .in_clk(in_clk), .in_rst(in_rst), .in_btn(in_btn),
    .out_level(lvl1), .out_rise(rise1), .out_fall(fall1),
    .out_toggle(tog1), .out_busy(busy1)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = -100;
  logic samp [4096];
  bit m_level [2];
  bit m_toggle [2];
  int m_run [2];
  int rise_cnt [2];
  int fall_cnt [2];
  int last_rise [2];
  int last_fall [2];

  function automatic int sstages(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int stable(input int c);
    return (c == 0) ? 5 : 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: the FSM sees in_btn delayed by SYNC_STAGES edges (zero after reset);
  // a level change is accepted once STABLE_CYCLES+1 consecutive samples differ.
  initial begin
    forever begin
      @(posedge in_clk);
      #1;
      cyc++;
      if (cyc < 4096) samp[cyc] = in_btn;
      if (!in_rst) last_rst = cyc;
      for (int c = 0; c < 2; c++) begin
        logic [4:0] expv;
        logic [4:0] act;
        int idx;
        bit s;
        bit rise;
        bit fall;
        act = (c == 0) ? d0 : d1;
        if (!in_rst) begin
          m_level[c]  = 1'b0;
          m_toggle[c] = 1'b0;
          m_run[c]    = 0;
          expv        = '0;
        end else begin
          idx  = cyc - sstages(c);
          s    = (idx > last_rst && idx >= 1 && idx < 4096) ? samp[idx] : 1'b0;
          rise = 1'b0;
          fall = 1'b0;
          if (s != m_level[c]) m_run[c]++;
          else m_run[c] = 0;
          if (m_run[c] == stable(c) + 1) begin
            m_level[c] = !m_level[c];
            m_run[c]   = 0;
            if (m_level[c]) begin
              rise = 1'b1;
              m_toggle[c] = !m_toggle[c];
            end else begin
              fall = 1'b1;
            end
          end
          expv = {m_level[c], rise, fall, m_toggle[c], m_run[c] != 0};
        end
        chk((c == 0) ? "outputs_cfg0" : "outputs_cfg1", int'(act), int'(expv));
        if (act[3]) begin rise_cnt[c]++; last_rise[c] = cyc; end
        if (act[2]) begin fall_cnt[c]++; last_fall[c] = cyc; end
      end
    end
  end

  task automatic hold(input bit v, input int n, output int k);
    @(negedge in_clk);
    in_btn = v;
    k = cyc + 1;
    repeat (n - 1) @(negedge in_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cfg0"}, int'(d0), 0);
    chk({tag, "_cfg1"}, int'(d1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int k, k2, r0, r1, f0;
    #1 in_rst = 1'b0;
    #1 chk_zero("reset_async");
    repeat (2) @(negedge in_clk);
    #1 in_rst = 1'b1;

    // clean press and release
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    hold(1'b1, 12, k);
    chk("press_rise_count0", rise_cnt[0] - r0, 1);
    chk("press_rise_edge0", last_rise[0], k + 7);
    chk("press_rise_count1", rise_cnt[1] - r1, 1);
    chk("press_rise_edge1", last_rise[1], k + 4);
    chk("press_toggle0", int'(tog0), 1);
    f0 = fall_cnt[0];
    hold(1'b0, 12, k);
    chk("release_fall_count0", fall_cnt[0] - f0, 1);
    chk("release_fall_edge0", last_fall[0], k + 7);
    chk("release_toggle0", int'(tog0), 1);

    // 5-cycle glitch rejected, 6-cycle pulse accepted
    r0 = rise_cnt[0];
    hold(1'b1, 5, k);
    hold(1'b0, 12, k2);
    chk("glitch5_rise_count0", rise_cnt[0] - r0, 0);
    chk("glitch5_busy0", int'(busy0), 0);
    r0 = rise_cnt[0];
    hold(1'b1, 6, k);
    hold(1'b0, 12, k2);
    chk("pulse6_rise_count0", rise_cnt[0] - r0, 1);
    chk("pulse6_rise_edge0", last_rise[0], k + 7);
    chk("second_cycle_toggle0", int'(tog0), 0);

    // bouncy press 1,0,1,1,0 then held
    r0 = rise_cnt[0];
    hold(1'b1, 1, k);
    hold(1'b0, 1, k);
    hold(1'b1, 2, k);
    hold(1'b0, 1, k);
    hold(1'b1, 12, k);
    chk("bouncy_rise_count0", rise_cnt[0] - r0, 1);
    chk("bouncy_rise_edge0", last_rise[0], k + 7);
    hold(1'b0, 12, k);

    // short-window configuration: 1-cycle glitch rejected, 2-cycle accepted
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    hold(1'b1, 1, k);
    hold(1'b0, 6, k2);
    chk("glitch1_rise_count1", rise_cnt[1] - r1, 0);
    r1 = rise_cnt[1];
    hold(1'b1, 2, k);
    hold(1'b0, 6, k2);
    chk("pulse2_rise_count1", rise_cnt[1] - r1, 1);
    chk("pulse2_rise_edge1", last_rise[1], k + 4);
    chk("short_pulses_rise_count0", rise_cnt[0] - r0, 0);
    hold(1'b0, 6, k2);

    // reset while waiting at ctr=3 with the button held high
    @(negedge in_clk);
    in_btn = 1'b1;
    k = cyc + 1;
    repeat (6) @(posedge in_clk);
    #2;
    chk("busy_before_reset0", int'(busy0), 1);
    in_rst = 1'b0;
    #1 chk_zero("reset_in_wait");
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    @(negedge in_clk);
    @(negedge in_clk);
    #1 in_rst = 1'b1;
    k2 = cyc + 1;
    repeat (12) @(negedge in_clk);
    chk("post_reset_rise_count0", rise_cnt[0] - r0, 1);
    chk("post_reset_rise_edge0", last_rise[0], k2 + 7);
    chk("post_reset_rise_count1", rise_cnt[1] - r1, 1);
    chk("post_reset_rise_edge1", last_rise[1], k2 + 4);
    hold(1'b0, 12, k);

    // randomized bouncing with occasional resets
    for (int i = 0; i < 200; i++) begin
      bit v;
      int n;
      if ($urandom_range(0, 24) == 0) begin
        @(negedge in_clk);
        #1 in_rst = 1'b0;
        #1 chk_zero("reset_random");
        @(negedge in_clk);
        #1 in_rst = 1'b1;
      end
      v = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 9));
      hold(v, n, k);
    end
    hold(1'b0, 12, k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
